// File: rtl/fp_mul_pkg.sv
// fp_mul_pkg: shared types for the FP32 multiplier result buffer.
// Holds the result class enumeration, the IEEE-754 single-precision field
// widths, the packed buffer entry layout and the classify() helper.
package fp_mul_pkg;

  localparam int unsigned EXP_W = 8;
  localparam int unsigned MAN_W = 23;
  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

  typedef enum logic [2:0] {
    FP_ZERO = 3'd0,
    FP_SUB  = 3'd1,
    FP_NORM = 3'd2,
    FP_INF  = 3'd3,
    FP_NAN  = 3'd4
  } fp_class_e;

  typedef struct packed {
    logic [31:0] fp_z;
    logic        ovrf;
    logic        udrf;
    logic [2:0]  r_mode;
    fp_class_e   cls;
  } mul_res_t;

  // Sign bit is deliberately ignored: -0 is zero, -inf is inf, etc.
  function automatic fp_class_e classify(input logic [31:0] fp_z);
    logic [EXP_W-1:0] exp_f;
    logic [MAN_W-1:0] man_f;
    exp_f = fp_z[30:23];
    man_f = fp_z[22:0];
    if (exp_f == '0) begin
      return (man_f == '0) ? FP_ZERO : FP_SUB;
    end else if (exp_f == EXP_MAX) begin
      return (man_f == '0) ? FP_INF : FP_NAN;
    end
    return FP_NORM;
  endfunction

endpackage

// File: rtl/fp_mul_result_buffer_if.sv
// fp_mul_result_buffer_if: both handshakes of the result buffer.
//   in_*  : producer (multiplier) -> buffer, valid/ready
//   out_* : buffer -> consumer, valid/ready, plus result class
// Modports: slave = the buffer itself, master = the environment driving it.
interface fp_mul_result_buffer_if;

  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_fp_z;
  logic        in_ovrf;
  logic        in_udrf;
  logic [2:0]  in_r_mode;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_fp_z;
  logic        out_ovrf;
  logic        out_udrf;
  logic [2:0]  out_r_mode;
  logic [2:0]  out_class;

  modport slave (
    input  in_valid, in_fp_z, in_ovrf, in_udrf, in_r_mode, out_ready,
    output in_ready, out_valid, out_fp_z, out_ovrf, out_udrf, out_r_mode, out_class
  );

  modport master (
    output in_valid, in_fp_z, in_ovrf, in_udrf, in_r_mode, out_ready,
    input  in_ready, out_valid, out_fp_z, out_ovrf, out_udrf, out_r_mode, out_class
  );

endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered pointers and occupancy.
// Ports:
//   clk_i, rst_ni      clock, async active-low reset
//   push_i / pop_i     write / read requests (ignored when full / empty)
//   wdata_i / rdata_o  write data / head entry (combinational from storage)
//   full_o, empty_o    derived from occupancy, not from pointer equality
//   count_o            occupancy, 0..DEPTH
// DEPTH must be a power of two (>= 2) so the pointers wrap by overflow.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FullCnt = (AW+1)'(DEPTH);

  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic do_push, do_pop;

  assign full_o  = (count_q == FullCnt);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rptr_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage is not reset; stale entries are never visible because the
  // consumer side gates its outputs on empty.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/fp_mul_result_buffer.sv
// fp_mul_result_buffer: downstream stage of the FP32 multiplier.
// Classifies each accepted result, queues it in a DEPTH-entry FIFO behind
// valid/ready handshakes and keeps saturating overflow/underflow/NaN counters.
// Ports:
//   clk, rst_n    clock, async active-low reset
//   bus (slave)   in_* producer handshake and out_* consumer handshake
//   clr_cnt       synchronous clear of the event counters (wins over increment)
//   count         FIFO occupancy
//   ovrf_cnt, udrf_cnt, nan_cnt  saturating event counters, CW bits
module fp_mul_result_buffer
  import fp_mul_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CW    = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  fp_mul_result_buffer_if.slave  bus,
  input  logic                   clr_cnt,
  output logic [$clog2(DEPTH):0] count,
  output logic [CW-1:0]          ovrf_cnt,
  output logic [CW-1:0]          udrf_cnt,
  output logic [CW-1:0]          nan_cnt
);

  localparam logic [CW-1:0] CntMax = '1;

  mul_res_t wr_entry;
  mul_res_t head_entry;
  logic     full, empty, push, pop;

  logic [CW-1:0] ovrf_cnt_q, ovrf_cnt_d;
  logic [CW-1:0] udrf_cnt_q, udrf_cnt_d;
  logic [CW-1:0] nan_cnt_q, nan_cnt_d;

  always_comb begin
    wr_entry.fp_z   = bus.in_fp_z;
    wr_entry.ovrf   = bus.in_ovrf;
    wr_entry.udrf   = bus.in_udrf;
    wr_entry.r_mode = bus.in_r_mode;
    wr_entry.cls    = classify(bus.in_fp_z);
  end

  assign bus.in_ready  = ~full;
  assign bus.out_valid = ~empty;
  assign push          = bus.in_valid & ~full;
  assign pop           = bus.out_ready & ~empty;

  sync_fifo #(
    .WIDTH ($bits(mul_res_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (wr_entry),
    .rdata_o (head_entry),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  // Head entry is shown directly from storage; zeroed while empty.
  always_comb begin
    bus.out_fp_z   = '0;
    bus.out_ovrf   = 1'b0;
    bus.out_udrf   = 1'b0;
    bus.out_r_mode = '0;
    bus.out_class  = '0;
    if (!empty) begin
      bus.out_fp_z   = head_entry.fp_z;
      bus.out_ovrf   = head_entry.ovrf;
      bus.out_udrf   = head_entry.udrf;
      bus.out_r_mode = head_entry.r_mode;
      bus.out_class  = head_entry.cls;
    end
  end

  always_comb begin
    ovrf_cnt_d = ovrf_cnt_q;
    udrf_cnt_d = udrf_cnt_q;
    nan_cnt_d  = nan_cnt_q;
    if (clr_cnt) begin
      ovrf_cnt_d = '0;
      udrf_cnt_d = '0;
      nan_cnt_d  = '0;
    end else if (push) begin
      if (wr_entry.ovrf && (ovrf_cnt_q != CntMax)) ovrf_cnt_d = ovrf_cnt_q + 1'b1;
      if (wr_entry.udrf && (udrf_cnt_q != CntMax)) udrf_cnt_d = udrf_cnt_q + 1'b1;
      if ((wr_entry.cls == FP_NAN) && (nan_cnt_q != CntMax)) nan_cnt_d = nan_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovrf_cnt_q <= '0;
      udrf_cnt_q <= '0;
      nan_cnt_q  <= '0;
    end else begin
      ovrf_cnt_q <= ovrf_cnt_d;
      udrf_cnt_q <= udrf_cnt_d;
      nan_cnt_q  <= nan_cnt_d;
    end
  end

  assign ovrf_cnt = ovrf_cnt_q;
  assign udrf_cnt = udrf_cnt_q;
  assign nan_cnt  = nan_cnt_q;

endmodule
